// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates at issue, captures CDB results, retires the head in order.
// Define ROB_PERF_COUNTER_EN to add the commitCount/flushCount outputs.
module reorder_buffer #(
   parameter int unsigned ROB_WIDTH = 4
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   input  logic                 issueValid,
   input  logic [1:0]           issueType,
   input  logic [4:0]           issueDest,
   input  logic                 issueReady,
   input  logic [31:0]          issueValue,
   output logic [ROB_WIDTH-1:0] issueRobId,
   output logic                 robFull,
   input  logic                 cdbValid,
   input  logic [ROB_WIDTH-1:0] cdbRobId,
   input  logic [31:0]          cdbValue,
   input  logic                 cdbMispredict,
   input  logic [31:0]          cdbTarget,
   input  logic [ROB_WIDTH-1:0] robRs1Dep,
   output logic                 robRs1Ready,
   output logic [31:0]          robRs1Value,
   input  logic [ROB_WIDTH-1:0] robRs2Dep,
   output logic                 robRs2Ready,
   output logic [31:0]          robRs2Value,
   output logic                 regUpdateValid,
   output logic [4:0]           regUpdateDest,
   output logic [31:0]          regUpdateValue,
   output logic [ROB_WIDTH-1:0] regUpdateRobId,
   output logic                 storeCommitValid,
   output logic [ROB_WIDTH-1:0] storeCommitRobId,
   output logic                 clearOut,
   output logic [31:0]          clearPc
`ifdef ROB_PERF_COUNTER_EN
   ,
   output logic [31:0]          commitCount,
   output logic [31:0]          flushCount
`endif
);

   localparam int unsigned DEPTH = 1 << ROB_WIDTH;
   localparam int unsigned CNT_W = ROB_WIDTH + 1;

   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_STORE  = 2'd1;
   localparam logic [1:0] TYPE_BRANCH = 2'd2;
   localparam logic [1:0] TYPE_RSVD   = 2'd3;

   logic [ROB_WIDTH-1:0] head_q, tail_q;
   logic [CNT_W-1:0]     count_q;
   logic [DEPTH-1:0]     busy_q, ready_q, misp_q;
   logic [1:0]           type_q   [DEPTH];
   logic [4:0]           dest_q   [DEPTH];
   logic [31:0]          value_q  [DEPTH];
   logic [31:0]          target_q [DEPTH];

   logic       commit_c, flush_c, issue_c, cdb_hit_c;
   logic [1:0] issue_type_c;

   assign robFull    = (count_q == CNT_W'(DEPTH));
   assign issueRobId = tail_q;

   // Retire/flush/issue decisions for the coming edge
   always_comb begin
      commit_c     = busy_q[head_q] && ready_q[head_q];
      flush_c      = commit_c && (type_q[head_q] == TYPE_BRANCH) && misp_q[head_q];
      issue_c      = issueValid && !robFull && !clearOut;
      cdb_hit_c    = cdbValid && busy_q[cdbRobId];
      issue_type_c = (issueType == TYPE_RSVD) ? TYPE_REG : issueType;
   end

   // Dependency lookups with same-cycle CDB bypass
   always_comb begin
      robRs1Ready = ready_q[robRs1Dep];
      robRs1Value = value_q[robRs1Dep];
      robRs2Ready = ready_q[robRs2Dep];
      robRs2Value = value_q[robRs2Dep];
      if (cdbValid && (cdbRobId == robRs1Dep)) begin
         robRs1Ready = 1'b1;
         robRs1Value = cdbValue;
      end
      if (cdbValid && (cdbRobId == robRs2Dep)) begin
         robRs2Ready = 1'b1;
         robRs2Value = cdbValue;
      end
   end

   // Entry payload; only meaningful while the matching busy bit is set
   always_ff @(posedge clockIn) begin
      if (cdb_hit_c && !flush_c) begin
         value_q[cdbRobId]  <= cdbValue;
         target_q[cdbRobId] <= cdbTarget;
      end
      if (issue_c && !flush_c) begin
         type_q[tail_q]  <= issue_type_c;
         dest_q[tail_q]  <= issueDest;
         value_q[tail_q] <= issueValue;
      end
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         head_q           <= '0;
         tail_q           <= '0;
         count_q          <= '0;
         busy_q           <= '0;
         ready_q          <= '0;
         misp_q           <= '0;
         regUpdateValid   <= 1'b0;
         regUpdateDest    <= '0;
         regUpdateValue   <= '0;
         regUpdateRobId   <= '0;
         storeCommitValid <= 1'b0;
         storeCommitRobId <= '0;
         clearOut         <= 1'b0;
         clearPc          <= '0;
      end else begin
         regUpdateValid   <= 1'b0;
         storeCommitValid <= 1'b0;
         clearOut         <= 1'b0;
         if (flush_c) begin
            // Mispredicted branch at head squashes everything younger
            busy_q   <= '0;
            ready_q  <= '0;
            misp_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            clearOut <= 1'b1;
            clearPc  <= target_q[head_q];
         end else begin
            if (cdb_hit_c) begin
               ready_q[cdbRobId] <= 1'b1;
               misp_q[cdbRobId]  <= cdbMispredict;
            end
            if (commit_c) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
               head_q          <= head_q + ROB_WIDTH'(1);
               if ((type_q[head_q] == TYPE_REG) && (dest_q[head_q] != 5'd0)) begin
                  regUpdateValid <= 1'b1;
                  regUpdateDest  <= dest_q[head_q];
                  regUpdateValue <= value_q[head_q];
                  regUpdateRobId <= head_q;
               end
               if (type_q[head_q] == TYPE_STORE) begin
                  storeCommitValid <= 1'b1;
                  storeCommitRobId <= head_q;
               end
            end
            if (issue_c) begin
               busy_q[tail_q]  <= 1'b1;
               ready_q[tail_q] <= issueReady;
               misp_q[tail_q]  <= 1'b0;
               tail_q          <= tail_q + ROB_WIDTH'(1);
            end
            count_q <= count_q + CNT_W'(issue_c) - CNT_W'(commit_c);
         end
      end
   end

`ifdef ROB_PERF_COUNTER_EN
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         commitCount <= '0;
         flushCount  <= '0;
      end else begin
         if (commit_c) commitCount <= commitCount + 32'd1;
         if (flush_c)  flushCount  <= flushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a program-order queue model.
`timescale 1ns/1ps
module tb_reorder_buffer;
   localparam int DEPTH = 16;

   logic        clockIn = 1'b0;
   logic        resetIn;
   logic        issueValid, issueReady;
   logic [1:0]  issueType;
   logic [4:0]  issueDest;
   logic [31:0] issueValue;
   logic [3:0]  issueRobId;
   logic        robFull;
   logic        cdbValid, cdbMispredict;
   logic [3:0]  cdbRobId;
   logic [31:0] cdbValue, cdbTarget;
   logic [3:0]  robRs1Dep, robRs2Dep;
   logic        robRs1Ready, robRs2Ready;
   logic [31:0] robRs1Value, robRs2Value;
   logic        regUpdateValid, storeCommitValid, clearOut;
   logic [4:0]  regUpdateDest;
   logic [31:0] regUpdateValue, clearPc;
   logic [3:0]  regUpdateRobId, storeCommitRobId;
`ifdef ROB_PERF_COUNTER_EN
   logic [31:0] commitCount, flushCount;
`endif

   reorder_buffer #(.ROB_WIDTH(4)) dut (
      .clockIn(clockIn), .resetIn(resetIn),
      .issueValid(issueValid), .issueType(issueType), .issueDest(issueDest),
      .issueReady(issueReady), .issueValue(issueValue), .issueRobId(issueRobId),
      .robFull(robFull), .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
      .cdbMispredict(cdbMispredict), .cdbTarget(cdbTarget),
      .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
      .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
      .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
      .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
      .storeCommitValid(storeCommitValid), .storeCommitRobId(storeCommitRobId),
      .clearOut(clearOut), .clearPc(clearPc)
`ifdef ROB_PERF_COUNTER_EN
      , .commitCount(commitCount), .flushCount(flushCount)
`endif
   );

   always #5 clockIn = ~clockIn;

   typedef struct {
      int          id;
      logic [1:0]  typ;
      logic [4:0]  dest;
      logic [31:0] value;
      logic        rdy;
      logic        misp;
      logic [31:0] target;
   } ent_t;

   typedef struct {
      int          cyc;
      logic [2:0]  kind;   // {clear, store, reg}
      logic [4:0]  dest;
      logic [31:0] value;
      logic [3:0]  id;
      logic [31:0] pc;
   } evt_t;

   ent_t rob_q[$];
   evt_t exp_q[$];
   int   m_head = 0;
   bit   m_clear = 0;
   int   m_commits = 0, m_flushes = 0;
   int   edges = 0;
   int   checks = 0, errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_idx(int id);
      int idx;
      idx = (id - m_head + DEPTH) % DEPTH;
      return (idx < rob_q.size()) ? idx : -1;
   endfunction

   function automatic int m_tail();
      return (m_head + rob_q.size()) % DEPTH;
   endfunction

   task automatic check_query(string nm, logic [3:0] dep, logic rdy, logic [31:0] val);
      int idx;
      if (cdbValid && (cdbRobId == dep)) begin
         check({nm, "_bypass_ready"}, 32'(rdy), 32'd1);
         check({nm, "_bypass_value"}, val, cdbValue);
      end else begin
         idx = find_idx(int'(dep));
         if (idx >= 0) begin
            check({nm, "_ready"}, 32'(rdy), 32'(rob_q[idx].rdy));
            if (rob_q[idx].rdy) check({nm, "_value"}, val, rob_q[idx].value);
         end
      end
   endtask

   // Check combinational outputs, advance the model across the next edge, then wait for negedge
   task automatic tick();
      ent_t e;
      evt_t ev;
      bit   full, com, flush;
      int   idx, tail;
      #1;
      full = (rob_q.size() == DEPTH);
      tail = m_tail();
      check("robFull", 32'(robFull), 32'(full));
      check("issueRobId", 32'(issueRobId), 32'(tail));
      check_query("rs1", robRs1Dep, robRs1Ready, robRs1Value);
      check_query("rs2", robRs2Dep, robRs2Ready, robRs2Value);
      com   = (rob_q.size() > 0) && rob_q[0].rdy;
      flush = 0;
      if (com) begin
         e = rob_q[0];
         ev.cyc = edges + 1; ev.kind = 3'b000; ev.dest = 5'd0; ev.value = 32'd0;
         ev.id = 4'(e.id); ev.pc = 32'd0;
         m_commits++;
         if (e.typ == 2'd0 && e.dest != 5'd0) begin
            ev.kind = 3'b001; ev.dest = e.dest; ev.value = e.value;
         end else if (e.typ == 2'd1) begin
            ev.kind = 3'b010;
         end else if (e.typ == 2'd2 && e.misp) begin
            ev.kind = 3'b100; ev.pc = e.target; flush = 1;
         end
         if (ev.kind != 3'b000) exp_q.push_back(ev);
      end
      if (flush) begin
         rob_q.delete();
         m_head = 0;
         m_flushes++;
      end else begin
         if (cdbValid) begin
            idx = find_idx(int'(cdbRobId));
            if (idx >= 0) begin
               rob_q[idx].rdy    = 1'b1;
               rob_q[idx].value  = cdbValue;
               rob_q[idx].misp   = cdbMispredict;
               rob_q[idx].target = cdbTarget;
            end
         end
         if (com) begin
            void'(rob_q.pop_front());
            m_head = (m_head + 1) % DEPTH;
         end
         if (issueValid && !full && !m_clear) begin
            e.id = tail; e.typ = (issueType == 2'd3) ? 2'd0 : issueType;
            e.dest = issueDest; e.value = issueValue; e.rdy = issueReady;
            e.misp = 1'b0; e.target = 32'd0;
            rob_q.push_back(e);
         end
      end
      m_clear = flush;
      @(negedge clockIn);
   endtask

   task automatic set_idle();
      issueValid = 0; issueType = 0; issueDest = 0; issueReady = 0; issueValue = 0;
      cdbValid = 0; cdbRobId = 0; cdbValue = 0; cdbMispredict = 0; cdbTarget = 0;
      robRs1Dep = 4'($urandom); robRs2Dep = 4'($urandom);
   endtask

   task automatic t_issue(logic [1:0] typ, logic [4:0] dest, logic rdy, logic [31:0] val);
      set_idle();
      issueValid = 1; issueType = typ; issueDest = dest; issueReady = rdy; issueValue = val;
      tick();
   endtask

   task automatic t_cdb(int id, logic [31:0] val, logic misp, logic [31:0] tgt);
      set_idle();
      cdbValid = 1; cdbRobId = 4'(id); cdbValue = val; cdbMispredict = misp; cdbTarget = tgt;
      tick();
   endtask

   task automatic t_idle(int n);
      for (int k = 0; k < n; k++) begin
         set_idle();
         tick();
      end
   endtask

   // Resolve every outstanding entry without mispredicts
   task automatic drain();
      int pick;
      for (int k = 0; k < 200 && rob_q.size() > 0; k++) begin
         pick = -1;
         for (int j = 0; j < rob_q.size(); j++)
            if (pick < 0 && !rob_q[j].rdy) pick = j;
         if (pick >= 0) t_cdb(rob_q[pick].id, $urandom, 1'b0, 32'd0);
         else t_idle(1);
      end
      check("drain_empty", 32'(rob_q.size()), 32'd0);
      t_idle(3);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_robFull"}, 32'(robFull), 32'd0);
      check({tag, "_issueRobId"}, 32'(issueRobId), 32'd0);
      check({tag, "_rs1Ready"}, 32'(robRs1Ready), 32'd0);
      check({tag, "_regUpdateValid"}, 32'(regUpdateValid), 32'd0);
      check({tag, "_regUpdateDest"}, 32'(regUpdateDest), 32'd0);
      check({tag, "_regUpdateValue"}, regUpdateValue, 32'd0);
      check({tag, "_regUpdateRobId"}, 32'(regUpdateRobId), 32'd0);
      check({tag, "_storeCommitValid"}, 32'(storeCommitValid), 32'd0);
      check({tag, "_storeCommitRobId"}, 32'(storeCommitRobId), 32'd0);
      check({tag, "_clearOut"}, 32'(clearOut), 32'd0);
      check({tag, "_clearPc"}, clearPc, 32'd0);
`ifdef ROB_PERF_COUNTER_EN
      check({tag, "_commitCount"}, commitCount, 32'd0);
      check({tag, "_flushCount"}, flushCount, 32'd0);
`endif
   endtask

   // Asynchronous reset applied and released between edges
   task automatic reset_mid();
      set_idle();
      resetIn = 0;
      #1;
      check_reset_outputs("midreset");
      rob_q.delete();
      m_head = 0; m_clear = 0; m_commits = 0; m_flushes = 0;
      resetIn = 1;
      #1;
   endtask

   // Monitor: pops the expected commit for each edge and compares the registered pulses
   initial begin
      evt_t ev;
      forever begin
         @(posedge clockIn);
         #1;
         edges++;
         while (exp_q.size() > 0 && exp_q[0].cyc < edges) begin
            ev = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_commit kind actual=000 required=%b id=%0d edge=%0d", ev.kind, ev.id, ev.cyc);
         end
         if (regUpdateValid || storeCommitValid || clearOut) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edges) begin
               ev = exp_q.pop_front();
               check("commit_kind", 32'({clearOut, storeCommitValid, regUpdateValid}), 32'(ev.kind));
               if (ev.kind == 3'b001) begin
                  check("regUpdateDest", 32'(regUpdateDest), 32'(ev.dest));
                  check("regUpdateValue", regUpdateValue, ev.value);
                  check("regUpdateRobId", 32'(regUpdateRobId), 32'(ev.id));
               end else if (ev.kind == 3'b010) begin
                  check("storeCommitRobId", 32'(storeCommitRobId), 32'(ev.id));
               end else begin
                  check("clearPc", clearPc, ev.pc);
               end
            end else begin
               checks++; errors++;
               $display("FAIL unexpected_commit kind actual=%b required=000 edge=%0d",
                        {clearOut, storeCommitValid, regUpdateValid}, edges);
            end
         end
      end
   end

   initial begin
      int ipct, cpct, br, st;
      resetIn = 0;
      set_idle();
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clockIn);
      @(negedge clockIn);
      resetIn = 1;

      // Register op resolved by CDB
      t_issue(2'd0, 5'd5, 1'b0, 32'd0);
      t_cdb(0, 32'h1234, 1'b0, 32'd0);
      t_idle(3);

      // Fill to full, drop the 17th, free one slot, wrap the tail
      for (int i = 0; i < 17; i++) t_issue(2'd0, 5'(i + 1), 1'b0, 32'(i));
      t_cdb(m_head, 32'hA0A0, 1'b0, 32'd0);
      t_idle(2);
      t_issue(2'd3, 5'd9, 1'b0, 32'd0);
      drain();

      // Same-cycle CDB bypass on rs1
      set_idle();
      robRs1Dep = 4'd3; cdbValid = 1; cdbRobId = 4'd3; cdbValue = 32'hDEAD;
      tick();

      // Branch mispredict squashes younger ops; issue during clearOut is dropped
      br = m_tail();
      t_issue(2'd2, 5'd0, 1'b0, 32'd0);
      t_issue(2'd0, 5'd7, 1'b1, 32'd11);
      t_issue(2'd0, 5'd8, 1'b1, 32'd12);
      t_cdb(br, 32'd0, 1'b1, 32'h80);
      t_idle(1);
      t_issue(2'd0, 5'd4, 1'b1, 32'd99);
      t_idle(2);

      // Store then ready register op retire in order
      st = m_tail();
      t_issue(2'd1, 5'd0, 1'b0, 32'd0);
      t_issue(2'd0, 5'd6, 1'b1, 32'd7);
      t_cdb(st, 32'd0, 1'b0, 32'd0);
      t_idle(3);

      // Reset with five busy entries
      for (int i = 0; i < 5; i++) t_issue(2'd0, 5'(i + 1), 1'b0, 32'(i));
      reset_mid();
      t_idle(2);

      for (int c = 0; c < 3000; c++) begin
         case ((c / 200) % 3)
            0: begin ipct = 90; cpct = 20; end
            1: begin ipct = 50; cpct = 50; end
            default: begin ipct = 20; cpct = 80; end
         endcase
         if (c == 1500) reset_mid();
         set_idle();
         issueValid = ($urandom_range(0, 99) < ipct);
         issueType  = 2'($urandom_range(0, 3));
         issueDest  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         issueReady = ($urandom_range(0, 3) == 0);
         issueValue = $urandom;
         if ($urandom_range(0, 99) < cpct) begin
            cdbValid = 1;
            if (rob_q.size() > 0 && $urandom_range(0, 7) != 0)
               cdbRobId = 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id);
            else
               cdbRobId = 4'($urandom);
            cdbValue      = $urandom;
            cdbMispredict = ($urandom_range(0, 7) == 0);
            cdbTarget     = $urandom;
         end
         if (rob_q.size() > 0 && $urandom_range(0, 1) == 1)
            robRs1Dep = 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id);
         if ($urandom_range(0, 3) == 0) robRs2Dep = cdbRobId;
         tick();
      end
      drain();

`ifdef ROB_PERF_COUNTER_EN
      check("commitCount", commitCount, 32'(m_commits));
      check("flushCount", flushCount, 32'(m_flushes));
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expected actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
